microstep_ref_gen: RTL and testbench
====================================

// Module: microstep_ref_gen
// PURPOSE
// Parametrised successor of the stepper-drive Interface block: converts step/direction
// pulses (CP, CCW) with a microstep subdivision level into PHASES sine reference words
// for the current-loop DACs. Single shared sine ROM read time-multiplexed per phase.
// Outputs are double-buffered with a commit step. Adds enable, idle hold-current
// reduction, busy/overrun status and a pending-step buffer.
// PARAMETERS
// REF_W      12             reference word width; midscale MID = 2^(REF_W-1)
// LUT_AW     8              ROM address width; one electrical period = 2^LUT_AW entries
// PHASES     3              number of phase outputs, 2..4
// SUB_W      4              SubLevel width
// IDLE_CYC   1000           CLK cycles without accepted step before HOLD asserts
// HOLD_SCALE 8              hold amplitude in 1/16 units (16 = full)
// ROM_FILE   "sin_lut.hex"  entry k = clamp(round((MID-1)*sin(2*pi*k/2^LUT_AW))+MID)
// PORTS
// CLK       in   1              system clock, rising edge
// rst       in   1              asynchronous reset, active high
// EN        in   1              drive enable
// CP        in   1              step pulse, asynchronous; one step per rising edge
// CCW       in   1              direction: 1 = angle increments, 0 = decrements
// SubLevel  in   SUB_W          subdivision level, sampled when a step is accepted
// REF       out  PHASES*REF_W   phase k at bits [k*REF_W +: REF_W]
// ANGLE     out  LUT_AW         electrical angle accumulator
// BUSY      out  1              refresh sequence in progress
// HOLD      out  1              hold-current reduction active
// OVR       out  1              sticky: step dropped (pending buffer full)
// BEHAVIOUR
// - Reset: ANGLE=0, every REF phase=MID, BUSY=0, HOLD=0, OVR=0, pending=0, idle cnt=0.
//   Reset release schedules a refresh, so REF shows angle 0 once it completes.
// - CP goes through a 2-FF synchroniser plus an edge register. A step event is a 0->1
//   transition at the synchroniser output; events while EN=0 are discarded.
// - Increment: inc = 2^(LUT_AW-2-s), s = min(SubLevel, LUT_AW-2). SubLevel 0 = quarter
//   period per step. ANGLE +/- inc is modulo 2^LUT_AW (wraps silently).
// - Phase k ROM address = ANGLE + (k*2^LUT_AW)/PHASES, integer-truncated, mod 2^LUT_AW.
// - FSM IDLE -> ACCEPT -> READ(k=0..PHASES-1) -> COMMIT -> IDLE.
//   ACCEPT: apply inc, clear idle cnt, HOLD=0.
//   READ: synchronous ROM, 1-cycle latency; result scaled into shadow[k].
//   COMMIT: all REF phases take shadow values on the same edge.
//   BUSY=1 from ACCEPT through COMMIT.
// - Latency: REF changes exactly PHASES+3 CLK cycles after the step event is seen in IDLE.
// - Refresh without a step (reset release, HOLD entry, EN rise) enters READ directly,
//   with no angle change.
// - Step during BUSY: stored in one-deep pending (direction and SubLevel sampled at the
//   event). Served immediately after COMMIT. A further step while pending is full is
//   dropped and sets OVR. OVR is cleared only by rst.
// - Scaling: REF = MID + ((rom-MID)*scale)>>>4, signed arithmetic, REF_W+5 bit
//   intermediate. scale = 16, or HOLD_SCALE while HOLD=1.
// - Idle cnt counts in IDLE with EN=1 and saturates at IDLE_CYC. On reaching IDLE_CYC:
//   HOLD=1 and one refresh. A step drops HOLD in ACCEPT, so its refresh is full scale.
// - EN=0: FSM aborts to IDLE next cycle, REF all MID the cycle after EN falls, pending
//   cleared. ANGLE and HOLD kept. EN 0->1 schedules a refresh.
// - Simultaneous step event and idle timeout: step wins, HOLD stays 0.
// - rst mid-sequence returns to reset values immediately; no partial commit is visible.
// TESTING
// 1 Reset, EN=1, wait for BUSY fall -> ANGLE=0, REF phase0=2048, phase1=3829, phase2=292.
// 2 SubLevel=0, CCW=1, one CP pulse -> ANGLE=64, REF phase0=4095, PHASES+3 cycles after the event.
// 3 SubLevel=0, CCW=0 from 0 -> ANGLE=192, phase0=1; SubLevel=9 -> inc=1 (clamped); 256 CCW steps -> ANGLE=0 again.
// 4 Three CP edges within one refresh -> 2 steps applied, third dropped, OVR=1 until rst.
// 5 ANGLE=64, no steps for IDLE_CYC cycles -> HOLD=1, phase0=3071; next step -> HOLD=0, full scale.
// 6 EN 1->0 mid-READ -> REF all 2048, BUSY=0, ANGLE kept; EN 0->1 -> REF restored; rst mid-READ -> reset values.

Source files
------------

// File: rtl/microstep_ref_gen.sv
// microstep_ref_gen
// Converts step/direction pulses with a microstep subdivision level into PHASES sine
// reference words for the current-loop DACs. One shared sine ROM is read once per phase,
// one phase per cycle. Results collect in a shadow buffer, and all phases update REF on
// the same edge. Also provides enable, idle hold-current reduction, busy/overrun status
// and a one-deep pending-step buffer.
//
// The sine table is computed at elaboration from the ROM formula
//   entry k = clamp(round((MID-1)*sin(2*pi*k/2^LUT_AW)) + MID)
// so the design needs no external hex file.
//
// Ports
//   CLK       in   system clock, rising edge
//   rst       in   asynchronous reset, active high
//   EN        in   drive enable
//   CP        in   step pulse (asynchronous), one step per rising edge
//   CCW       in   direction: 1 = angle increments, 0 = decrements
//   SubLevel  in   subdivision level, sampled at the step event
//   REF       out  phase k reference at bits [k*REF_W +: REF_W]
//   ANGLE     out  electrical angle accumulator
//   BUSY      out  refresh sequence in progress
//   HOLD      out  hold-current reduction active
//   OVR       out  sticky: a step was dropped because the pending buffer was full
module microstep_ref_gen #(
    parameter int unsigned REF_W      = 12,
    parameter int unsigned LUT_AW     = 8,
    parameter int unsigned PHASES     = 3,
    parameter int unsigned SUB_W      = 4,
    parameter int unsigned IDLE_CYC   = 1000,
    parameter int unsigned HOLD_SCALE = 8
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     EN,
    input  logic                     CP,
    input  logic                     CCW,
    input  logic [SUB_W-1:0]         SubLevel,
    output logic [PHASES*REF_W-1:0]  REF,
    output logic [LUT_AW-1:0]        ANGLE,
    output logic                     BUSY,
    output logic                     HOLD,
    output logic                     OVR
);

    localparam int unsigned N    = 2 ** LUT_AW;
    localparam int unsigned MID  = 2 ** (REF_W - 1);
    localparam int unsigned KW   = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int unsigned CW   = $clog2(IDLE_CYC + 1);
    localparam int unsigned SMAX = LUT_AW - 2;
    // pi with 40 fractional bits
    localparam logic [43:0] PI_F = 44'h3243F6A8885;

    // Quarter-wave folded Taylor series in 40-bit fixed point; far more precision than
    // the rounding to REF_W bits needs.
    function automatic logic [N*REF_W-1:0] gen_lut();
        logic [N*REF_W-1:0] tbl;
        logic [127:0]       x, x2, term, pos, neg, mag;
        int unsigned        kk;
        int                 v;
        tbl = '0;
        for (int unsigned k = 0; k < N; k++) begin
            kk = k % (N / 2);
            if (kk > N / 4) kk = N / 2 - kk;
            x    = (128'(PI_F) * 128'(2 * kk)) >> LUT_AW;
            x2   = (x * x) >> 40;
            term = x;
            pos  = '0;
            neg  = '0;
            for (int unsigned n = 0; n < 12; n++) begin
                if (n[0]) neg = neg + term;
                else      pos = pos + term;
                term = ((term * x2) >> 40) / 128'((2 * n + 2) * (2 * n + 3));
            end
            // Round the magnitude, then apply the sign: round-half-away-from-zero.
            mag = ((pos - neg) * 128'(MID - 1) + (128'(1) << 39)) >> 40;
            if (k >= N / 2) v = int'(MID) - int'(mag);
            else            v = int'(MID) + int'(mag);
            if (v < 0) v = 0;
            if (v > int'(2 ** REF_W - 1)) v = int'(2 ** REF_W - 1);
            tbl[k*REF_W +: REF_W] = REF_W'(v);
        end
        return tbl;
    endfunction

    localparam logic [N*REF_W-1:0] LUT = gen_lut();

    // MID + ((rom - MID) * scale) >>> 4, signed, REF_W+5 bit intermediate.
    function automatic logic [REF_W-1:0] scale_ref(input logic [REF_W-1:0] rom,
                                                   input logic             hold);
        logic signed [REF_W+4:0] diff, sc, prod;
        diff = $signed({5'b0, rom}) - $signed((REF_W + 5)'(MID));
        sc   = hold ? (REF_W + 5)'(HOLD_SCALE) : (REF_W + 5)'(16);
        prod = (diff * sc) >>> 4;
        return REF_W'(prod + $signed((REF_W + 5)'(MID)));
    endfunction

    typedef enum logic [1:0] {StIdle, StAccept, StRead, StCommit} state_e;

    state_e                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [LUT_AW-1:0]         angle_q, angle_d;
    logic                      cdir_q, cdir_d;
    logic [SUB_W-1:0]          csub_q, csub_d;
    logic                      pend_q, pend_d;
    logic                      pdir_q, pdir_d;
    logic [SUB_W-1:0]          psub_q, psub_d;
    logic                      ovr_q, ovr_d;
    logic                      hold_q, hold_d;
    logic                      rf_q, rf_d;      // refresh owed without a step
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      en_q;
    logic                      cap_v_q, cap_v_d;
    logic [KW-1:0]             cap_k_q, cap_k_d;
    logic [PHASES*REF_W-1:0]   ref_q, ref_d;
    logic [REF_W-1:0]          shadow_q [PHASES];
    logic [REF_W-1:0]          shadow_nx [PHASES];
    logic [REF_W-1:0]          rom_q;
    logic [LUT_AW-1:0]         rom_addr;
    logic [LUT_AW-1:0]         inc;
    logic                      cp_s1, cp_s2, cp_s3;
    logic                      step_ev;
    logic                      take_ev, take_pend;

    assign step_ev = cp_s2 & ~cp_s3 & EN;

    // Synchronous ROM, one phase address per READ cycle.
    always_comb begin
        rom_addr = angle_q;
        for (int unsigned k = 0; k < PHASES; k++) begin
            if (k_q == KW'(k)) rom_addr = angle_q + LUT_AW'((k * N) / PHASES);
        end
    end

    always_ff @(posedge CLK) begin
        rom_q <= LUT[32'(rom_addr) * REF_W +: REF_W];
    end

    // ROM data arrives one cycle after its READ; scale it into the shadow slot then.
    always_comb begin
        for (int unsigned k = 0; k < PHASES; k++) begin
            shadow_nx[k] = shadow_q[k];
            if (cap_v_q && cap_k_q == KW'(k)) shadow_nx[k] = scale_ref(rom_q, hold_q);
        end
    end

    always_comb begin
        if (32'(csub_q) >= SMAX) inc = LUT_AW'(1);
        else                     inc = LUT_AW'(1) << (SMAX - 32'(csub_q));
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        angle_d   = angle_q;
        cdir_d    = cdir_q;
        csub_d    = csub_q;
        pend_d    = pend_q;
        pdir_d    = pdir_q;
        psub_d    = psub_q;
        ovr_d     = ovr_q;
        hold_d    = hold_q;
        rf_d      = rf_q | (EN & ~en_q);
        cnt_d     = cnt_q;
        cap_v_d   = 1'b0;
        cap_k_d   = k_q;
        ref_d     = ref_q;
        take_ev   = 1'b0;
        take_pend = 1'b0;

        case (state_q)
            StIdle: begin
                if (EN && cnt_q < CW'(IDLE_CYC)) cnt_d = cnt_q + 1'b1;
                if (pend_q) begin
                    take_pend = 1'b1;
                end else if (step_ev) begin
                    take_ev = 1'b1;
                end else if (EN && cnt_q == CW'(IDLE_CYC - 1)) begin
                    // Idle timeout: enter hold and redraw at reduced amplitude.
                    hold_d  = 1'b1;
                    rf_d    = 1'b0;
                    k_d     = '0;
                    state_d = StRead;
                end else if (EN && rf_q) begin
                    rf_d    = 1'b0;
                    k_d     = '0;
                    state_d = StRead;
                end
            end
            StAccept: begin
                angle_d = cdir_q ? angle_q + inc : angle_q - inc;
                cnt_d   = '0;
                hold_d  = 1'b0;
                k_d     = '0;
                state_d = StRead;
            end
            StRead: begin
                cap_v_d = 1'b1;
                cap_k_d = k_q;
                if (k_q == KW'(PHASES - 1)) state_d = StCommit;
                else                        k_d     = k_q + 1'b1;
            end
            StCommit: begin
                for (int unsigned k = 0; k < PHASES; k++) ref_d[k*REF_W +: REF_W] = shadow_nx[k];
                if (pend_q) take_pend = 1'b1;
                else        state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (take_pend) begin
            state_d = StAccept;
            cdir_d  = pdir_q;
            csub_d  = psub_q;
            pend_d  = 1'b0;
            rf_d    = 1'b0;
        end else if (take_ev) begin
            state_d = StAccept;
            cdir_d  = CCW;
            csub_d  = SubLevel;
            rf_d    = 1'b0;
        end

        // A step that cannot start now waits in the pending slot; the slot is free again
        // in the same cycle it is consumed.
        if (step_ev && !take_ev) begin
            if (!pend_q || take_pend) begin
                pend_d = 1'b1;
                pdir_d = CCW;
                psub_d = SubLevel;
            end else begin
                ovr_d = 1'b1;
            end
        end

        // Disable aborts everything except angle, hold state and the idle count.
        if (!EN) begin
            state_d = StIdle;
            k_d     = '0;
            pend_d  = 1'b0;
            cap_v_d = 1'b0;
            angle_d = angle_q;
            hold_d  = hold_q;
            cnt_d   = cnt_q;
            ref_d   = {PHASES{REF_W'(MID)}};
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cp_s1    <= 1'b0;
            cp_s2    <= 1'b0;
            cp_s3    <= 1'b0;
            state_q  <= StIdle;
            k_q      <= '0;
            angle_q  <= '0;
            cdir_q   <= 1'b0;
            csub_q   <= '0;
            pend_q   <= 1'b0;
            pdir_q   <= 1'b0;
            psub_q   <= '0;
            ovr_q    <= 1'b0;
            hold_q   <= 1'b0;
            rf_q     <= 1'b1;   // reset release owes one refresh
            cnt_q    <= '0;
            en_q     <= 1'b0;
            cap_v_q  <= 1'b0;
            cap_k_q  <= '0;
            ref_q    <= {PHASES{REF_W'(MID)}};
            for (int unsigned k = 0; k < PHASES; k++) shadow_q[k] <= REF_W'(MID);
        end else begin
            cp_s1    <= CP;
            cp_s2    <= cp_s1;
            cp_s3    <= cp_s2;
            state_q  <= state_d;
            k_q      <= k_d;
            angle_q  <= angle_d;
            cdir_q   <= cdir_d;
            csub_q   <= csub_d;
            pend_q   <= pend_d;
            pdir_q   <= pdir_d;
            psub_q   <= psub_d;
            ovr_q    <= ovr_d;
            hold_q   <= hold_d;
            rf_q     <= rf_d;
            cnt_q    <= cnt_d;
            en_q     <= EN;
            cap_v_q  <= cap_v_d;
            cap_k_q  <= cap_k_d;
            ref_q    <= ref_d;
            for (int unsigned k = 0; k < PHASES; k++) shadow_q[k] <= shadow_nx[k];
        end
    end

    assign REF   = ref_q;
    assign ANGLE = angle_q;
    assign BUSY  = (state_q != StIdle);
    assign HOLD  = hold_q;
    assign OVR   = ovr_q;

endmodule

// File: tb/tb_microstep_ref_gen.sv
// Directed bench for microstep_ref_gen with hand-computed reference words.
module tb_microstep_ref_gen;

    localparam int unsigned REF_W  = 12;
    localparam int unsigned LUT_AW = 8;
    localparam int unsigned PHASES = 3;
    localparam int unsigned SUB_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic                    cp;
    logic                    ccw;
    logic [SUB_W-1:0]        sub;
    logic [PHASES*REF_W-1:0] ref_w;
    logic [LUT_AW-1:0]       angle;
    logic                    busy;
    logic                    hold;
    logic                    ovr;

    int errors = 0;
    int checks = 0;

    microstep_ref_gen #(
        .REF_W      (REF_W),
        .LUT_AW     (LUT_AW),
        .PHASES     (PHASES),
        .SUB_W      (SUB_W),
        .IDLE_CYC   (1000),
        .HOLD_SCALE (8)
    ) dut (
        .CLK      (clk),
        .rst      (rst),
        .EN       (en),
        .CP       (cp),
        .CCW      (ccw),
        .SubLevel (sub),
        .REF      (ref_w),
        .ANGLE    (angle),
        .BUSY     (busy),
        .HOLD     (hold),
        .OVR      (ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [REF_W-1:0] ph(input int k);
        return ref_w[k*REF_W +: REF_W];
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        check("busy_fall", busy, 0);
    endtask

    task automatic step(input logic dir, input logic [SUB_W-1:0] s);
        @(negedge clk);
        ccw = dir;
        sub = s;
        cp  = 1'b1;
        @(negedge clk);
        cp = 1'b0;
        repeat (8) @(negedge clk);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within 2 ms");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        cp  = 1'b0;
        ccw = 1'b0;
        sub = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_angle", angle, 0);
        check("rst_ref", ref_w, {3{12'd2048}});
        check("rst_busy", busy, 0);
        check("rst_hold", hold, 0);
        check("rst_ovr", ovr, 0);

        // Reset release refresh at angle 0
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rel_busy", busy, 1);
        wait_idle();
        check("t1_angle", angle, 0);
        check("t1_ph0", ph(0), 2048);
        check("t1_ph1", ph(1), 3829);
        check("t1_ph2", ph(2), 292);

        // One quarter-period step with exact latency
        @(negedge clk);
        ccw = 1'b1;
        sub = 4'd0;
        cp  = 1'b1;
        @(negedge clk);
        cp = 1'b0;
        repeat (6) @(negedge clk);
        check("lat_busy", busy, 1);
        check("lat_early", ph(0), 2048);
        @(negedge clk);
        check("lat_edge", ph(0), 4095);
        check("t2_angle", angle, 64);
        check("t2_ph1", ph(1), 1039);
        check("t2_ph2", ph(2), 996);
        check("t2_busy", busy, 0);

        // Decrement with wrap, clamped subdivision, full wrap in fine steps
        step(1'b0, 4'd0);
        check("t3_dec0", angle, 0);
        step(1'b0, 4'd0);
        check("t3_wrap", angle, 192);
        check("t3_ph0", ph(0), 1);
        check("t3_ph1", ph(1), 3057);
        check("t3_ph2", ph(2), 3100);
        step(1'b1, 4'd0);
        check("t3_back0", angle, 0);
        step(1'b1, 4'd9);
        check("t3_clamp", angle, 1);
        for (int i = 0; i < 255; i++) step(1'b1, 4'd9);
        check("t3_full", angle, 0);

        // Idle hold-current reduction
        step(1'b1, 4'd0);
        check("t5_angle", angle, 64);
        check("t5_full", ph(0), 4095);
        repeat (990) @(negedge clk);
        check("t5_hold_early", hold, 0);
        for (int i = 0; i < 40 && !hold; i++) @(negedge clk);
        check("t5_hold_set", hold, 1);
        wait_idle();
        check("t5_h_ph0", ph(0), 3071);
        check("t5_h_ph1", ph(1), 1543);
        check("t5_h_ph2", ph(2), 1522);
        step(1'b1, 4'd0);
        check("t5_hold_drop", hold, 0);
        check("t5_angle2", angle, 128);
        check("t5_f_ph1", ph(1), 267);
        check("t5_f_ph2", ph(2), 3804);
        check("t4_ovr_pre", ovr, 0);

        // Three edges within one refresh: two applied, third dropped
        ccw = 1'b1;
        sub = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cp = 1'b1;
            @(negedge clk);
            cp = 1'b0;
        end
        repeat (20) @(negedge clk);
        wait_idle();
        check("t4_angle", angle, 192);
        check("t4_ovr", ovr, 1);

        // Disable mid-READ, then re-enable
        @(negedge clk);
        ccw = 1'b1;
        sub = 4'd1;
        cp  = 1'b1;
        @(negedge clk);
        cp = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_busy_mid", busy, 1);
        en = 1'b0;
        @(negedge clk);
        check("t6_dis_busy", busy, 0);
        check("t6_dis_ref", ref_w, {3{12'd2048}});
        check("t6_dis_angle", angle, 224);
        @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
        wait_idle();
        check("t6_en_ph0", ph(0), 601);
        check("t6_en_ph1", ph(1), 4021);
        check("t6_en_ph2", ph(2), 1551);
        check("t6_ovr_kept", ovr, 1);

        // Reset mid-READ
        @(negedge clk);
        ccw = 1'b1;
        sub = 4'd0;
        cp  = 1'b1;
        @(negedge clk);
        cp = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_angle", angle, 0);
        check("t6_rst_ref", ref_w, {3{12'd2048}});
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ovr", ovr, 0);
        check("t6_rst_hold", hold, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        wait_idle();
        check("t6_rel_ph1", ph(1), 3829);
        check("t6_rel_ph2", ph(2), 292);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
